// File: rtl/puf_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | puf_pkg : shared types and defaults for the RO-PUF sequencer      |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
package puf_pkg;

  localparam int CHALL_W           = 8;
  localparam int DEF_RESP_BITS     = 8;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_WIN_CYCLES    = 4096;
  localparam int DEF_CNT_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_COUNT   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } puf_state_t;

endpackage
`default_nettype wire

// File: rtl/ro_edge_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ro_edge_counter : 2-flop sync, rising-edge detect, saturating cnt |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             ro_in,
  output logic [CNT_W-1:0] cnt
);

  // [1:0] synchronizer, [2] previous synchronized level for edge detect
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  always_comb begin
    sync_d = {sync_q[1:0], ro_in};
    rise   = sync_q[1] & ~sync_q[2];
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && rise && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ro_puf_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ro_puf_ctrl : challenge stepping, RO settle/count, response build |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
module ro_puf_ctrl
  import puf_pkg::*;
#(
  parameter int RESP_BITS     = DEF_RESP_BITS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WIN_CYCLES    = DEF_WIN_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                 CLK100MHZ,
  input  logic                 CPU_RESETN,
  input  logic                 start,
  input  logic [CHALL_W-1:0]   challenge,
  output logic                 busy,
  output logic                 ro_en,
  output logic [CHALL_W-1:0]   chall,
  input  logic                 ro_in0,
  input  logic                 ro_in1,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  input  logic                 resp_ack
);

  localparam int CYC_MAX = (SETTLE_CYCLES > WIN_CYCLES) ? SETTLE_CYCLES : WIN_CYCLES;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int K_W     = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  puf_state_t           state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [CHALL_W-1:0]   base_q, base_d;
  logic [CHALL_W-1:0]   chall_q, chall_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic                 ro_en_q, ro_en_d;
  logic                 busy_q, busy_d;
  logic                 resp_valid_q, resp_valid_d;

  logic [CNT_W-1:0]     cnt0, cnt1;
  logic                 cnt_clr, cnt_en;

  // Counts are held through COMPARE so the decision sees the full window.
  assign cnt_en  = (state_q == ST_COUNT);
  assign cnt_clr = (state_q != ST_COUNT) && (state_q != ST_COMPARE);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt0 (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .ro_in (ro_in0),
    .cnt   (cnt0)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .ro_in (ro_in1),
    .cnt   (cnt1)
  );

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    k_d     = k_q;
    base_d  = base_q;
    chall_d = chall_q;
    resp_d  = resp_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          base_d  = challenge;
          chall_d = challenge;
          k_d     = '0;
          resp_d  = '0;
          cyc_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (cyc_q == CYC_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_COUNT;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_COUNT: begin
        if (cyc_q == CYC_W'(WIN_CYCLES - 1)) begin
          state_d = ST_COMPARE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_COMPARE: begin
        resp_d[k_q] = (cnt0 > cnt1);
        if (k_q == K_W'(RESP_BITS - 1)) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + K_W'(1);
          // 8-bit add wraps 0xFF -> 0x00 naturally
          chall_d = base_q + CHALL_W'(k_q) + CHALL_W'(1);
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        if (resp_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ro_en_d      = (state_d == ST_SETTLE) || (state_d == ST_COUNT);
    busy_d       = (state_d != ST_IDLE);
    resp_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q      <= ST_IDLE;
      cyc_q        <= '0;
      k_q          <= '0;
      base_q       <= '0;
      chall_q      <= '0;
      resp_q       <= '0;
      ro_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      k_q          <= k_d;
      base_q       <= base_d;
      chall_q      <= chall_d;
      resp_q       <= resp_d;
      ro_en_q      <= ro_en_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign busy       = busy_q;
  assign ro_en      = ro_en_q;
  assign chall      = chall_q;
  assign resp       = resp_q;
  assign resp_valid = resp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ro_puf_ctrl : randomized bench, two DUTs (CNT_W 16 and 4)      |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
module tb_ro_puf_ctrl;

  localparam int R       = 4;
  localparam int S       = 4;
  localparam int W       = 64;
  localparam int BIT_CYC = S + W + 1;
  localparam int LAT     = 1 + R * BIT_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ack = 1'b0;
  logic       ro_in0 = 1'b0;
  logic       ro_in1 = 1'b0;
  logic [7:0] challenge = 8'h00;

  logic         busy_a, ro_en_a, valid_a;
  logic [7:0]   chall_a;
  logic [R-1:0] resp_a;
  logic         busy_b, ro_en_b, valid_b;
  logic [7:0]   chall_b;
  logic [R-1:0] resp_b;

  int checks = 0;
  int errors = 0;

  // Per-bit oscillator periods (in clk cycles) applied by the waveform generator
  int per0[R] = '{4, 4, 4, 4};
  int per1[R] = '{4, 4, 4, 4};
  int pset[5] = '{4, 6, 8, 16, 32};

  int         obs_lat;
  logic [7:0] obs_chall[8];
  int         obs_nchall;
  int         obs_low_min, obs_low_max;
  int         obs_glitch;
  logic       obs_en_done;
  logic       obs_busy1;

  ro_puf_ctrl #(.RESP_BITS(R), .SETTLE_CYCLES(S), .WIN_CYCLES(W), .CNT_W(16)) dut_a (
    .CLK100MHZ (clk), .CPU_RESETN (rst_n), .start (start), .challenge (challenge),
    .busy (busy_a), .ro_en (ro_en_a), .chall (chall_a), .ro_in0 (ro_in0), .ro_in1 (ro_in1),
    .resp (resp_a), .resp_valid (valid_a), .resp_ack (ack)
  );

  ro_puf_ctrl #(.RESP_BITS(R), .SETTLE_CYCLES(S), .WIN_CYCLES(W), .CNT_W(4)) dut_b (
    .CLK100MHZ (clk), .CPU_RESETN (rst_n), .start (start), .challenge (challenge),
    .busy (busy_b), .ro_en (ro_en_b), .chall (chall_b), .ro_in0 (ro_in0), .ro_in1 (ro_in1),
    .resp (resp_b), .resp_valid (valid_b), .resp_ack (ack)
  );

  always #5 clk = ~clk;

  // Square-wave sources; each bit's periods start fresh when ro_en rises
  initial begin : gen
    int   gbit, ph0, ph1, cur;
    logic en_prev;
    gbit = -1; ph0 = 0; ph1 = 0; en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy_a) gbit = -1;
      cur = (gbit < 0) ? 0 : ((gbit > R - 1) ? R - 1 : gbit);
      if (ro_en_a && !en_prev) begin
        gbit = gbit + 1;
        cur  = (gbit > R - 1) ? R - 1 : gbit;
        ph0  = 0;
        ph1  = 0;
      end else begin
        ph0 = (ph0 + 1) % per0[cur];
        ph1 = (ph1 + 1) % per1[cur];
      end
      en_prev = ro_en_a;
      ro_in0  = (ph0 < per0[cur] / 2);
      ro_in1  = (ph1 < per1[cur] / 2);
    end
  end

  // Expected response: edges in a window = W/period, clipped at counter max
  function automatic logic [R-1:0] exp_resp(input int cw);
    logic [R-1:0] r;
    int mx, c0, c1;
    mx = (1 << cw) - 1;
    r  = '0;
    for (int k = 0; k < R; k++) begin
      c0 = W / per0[k];
      c1 = W / per1[k];
      if (c0 > mx) c0 = mx;
      if (c1 > mx) c1 = mx;
      r[k] = (c0 > c1);
    end
    return r;
  endfunction

  task automatic rand_periods();
    for (int k = 0; k < R; k++) begin
      per0[k] = pset[$urandom_range(0, 4)];
      per1[k] = pset[$urandom_range(0, 4)];
    end
  endtask

  // Issues one request and records what the DUT does until resp_valid (bounded)
  task automatic do_request(input logic [7:0] ch, input bit junk);
    logic       en_prev;
    logic [7:0] chall_prev;
    int         low;
    @(negedge clk);
    challenge = ch;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    challenge = ~ch;
    obs_lat = 0; obs_nchall = 0; obs_low_min = 1000; obs_low_max = 0;
    obs_glitch = 0; obs_en_done = 1'b1; obs_busy1 = 1'b0;
    en_prev = 1'b0; chall_prev = chall_a; low = 0;
    for (int n = 1; n <= 2000; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 1) obs_busy1 = busy_a & ro_en_a;
      if (junk && n == 100) begin
        start = 1'b1; challenge = 8'h55; ack = 1'b1;
      end
      if (junk && n == 101) begin
        start = 1'b0; ack = 1'b0;
      end
      if (ro_en_a && !en_prev) begin
        if (obs_nchall < 8) obs_chall[obs_nchall] = chall_a;
        if (obs_nchall > 0) begin
          if (low < obs_low_min) obs_low_min = low;
          if (low > obs_low_max) obs_low_max = low;
        end
        obs_nchall = obs_nchall + 1;
        low = 0;
      end
      if (!ro_en_a && busy_a && !valid_a) low = low + 1;
      if (ro_en_a && en_prev && (chall_a != chall_prev)) obs_glitch = obs_glitch + 1;
      chall_prev = chall_a;
      en_prev    = ro_en_a;
      if (valid_a) begin
        obs_lat     = n;
        obs_en_done = ro_en_a;
        break;
      end
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (ro_en_a !== 1'b0) begin errors++; $display("FAIL reset_ro_en: got %b expected 0", ro_en_a); end
    checks++; if (chall_a !== 8'h00) begin errors++; $display("FAIL reset_chall: got %h expected 00", chall_a); end
    checks++; if (resp_a !== 4'h0)  begin errors++; $display("FAIL reset_resp: got %h expected 0", resp_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
    checks++; if ({busy_b, ro_en_b, chall_b, resp_b, valid_b} !== 15'h0) begin
      errors++; $display("FAIL reset_dut_b: got %h expected 0", {busy_b, ro_en_b, chall_b, resp_b, valid_b});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b expected 0", busy_a); end
  endtask

  task automatic test_fixed();
    logic [7:0] base, e;
    for (int k = 0; k < R; k++) begin per0[k] = 4; per1[k] = 8; end
    base = 8'($urandom);
    do_request(base, 1'b0);
    checks++; if (obs_lat != LAT) begin errors++; $display("FAIL fixed_latency: got %0d expected %0d", obs_lat, LAT); end
    checks++; if (obs_busy1 !== 1'b1) begin errors++; $display("FAIL fixed_busy_t1: got %b expected 1", obs_busy1); end
    checks++; if (obs_nchall != R) begin errors++; $display("FAIL fixed_nbits: got %0d expected %0d", obs_nchall, R); end
    for (int k = 0; k < R; k++) begin
      e = base + 8'(k);
      checks++; if (obs_chall[k] !== e) begin errors++; $display("FAIL fixed_chall%0d: got %h expected %h", k, obs_chall[k], e); end
    end
    checks++; if (obs_low_min != 1 || obs_low_max != 1) begin
      errors++; $display("FAIL fixed_gap: got %0d..%0d expected 1..1", obs_low_min, obs_low_max);
    end
    checks++; if (obs_glitch != 0) begin errors++; $display("FAIL fixed_chall_stable: got %0d changes expected 0", obs_glitch); end
    checks++; if (obs_en_done !== 1'b0) begin errors++; $display("FAIL fixed_en_done: got %b expected 0", obs_en_done); end
    checks++; if (resp_a !== 4'b1111) begin errors++; $display("FAIL fixed_resp_a: got %b expected 1111", resp_a); end
    checks++; if (resp_b !== exp_resp(4) || valid_b !== 1'b1) begin
      errors++; $display("FAIL fixed_resp_b: got %b/%b expected %b/1", resp_b, valid_b, exp_resp(4));
    end
    do_ack();
  endtask

  task automatic test_pattern();
    int p;
    for (int k = 0; k < R; k++) begin
      per0[k] = (k % 2 == 1) ? 4 : 8;
      per1[k] = (k % 2 == 1) ? 8 : 4;
    end
    do_request(8'($urandom), 1'b0);
    checks++; if (resp_a !== 4'b1010) begin errors++; $display("FAIL alt_resp_a: got %b expected 1010", resp_a); end
    checks++; if (resp_b !== exp_resp(4)) begin errors++; $display("FAIL alt_resp_b: got %b expected %b", resp_b, exp_resp(4)); end
    do_ack();
    for (int k = 0; k < R; k++) begin
      p = pset[$urandom_range(0, 4)];
      per0[k] = p;
      per1[k] = p;
    end
    do_request(8'($urandom), 1'b0);
    checks++; if (resp_a !== 4'b0000) begin errors++; $display("FAIL tie_resp_a: got %b expected 0000", resp_a); end
    checks++; if (resp_b !== 4'b0000) begin errors++; $display("FAIL tie_resp_b: got %b expected 0000", resp_b); end
    do_ack();
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    rand_periods();
    do_request(8'hFE, 1'b0);
    for (int k = 0; k < R; k++) begin
      e = 8'hFE + 8'(k);
      checks++; if (obs_chall[k] !== e) begin errors++; $display("FAIL wrap_chall%0d: got %h expected %h", k, obs_chall[k], e); end
    end
    checks++; if (obs_low_min != 1 || obs_low_max != 1) begin
      errors++; $display("FAIL wrap_gap: got %0d..%0d expected 1..1", obs_low_min, obs_low_max);
    end
    checks++; if (obs_en_done !== 1'b0) begin errors++; $display("FAIL wrap_en_done: got %b expected 0", obs_en_done); end
    checks++; if (resp_a !== exp_resp(16)) begin errors++; $display("FAIL wrap_resp_a: got %b expected %b", resp_a, exp_resp(16)); end
    do_ack();
  endtask

  task automatic test_saturation();
    per0 = '{4, 4, 6, 4};
    per1 = '{6, 4, 4, 8};
    do_request(8'($urandom), 1'b0);
    checks++; if (resp_a !== exp_resp(16)) begin errors++; $display("FAIL sat_resp_a: got %b expected %b", resp_a, exp_resp(16)); end
    checks++; if (resp_b !== exp_resp(4)) begin errors++; $display("FAIL sat_resp_b: got %b expected %b", resp_b, exp_resp(4)); end
    do_ack();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      rand_periods();
      do_request(8'($urandom), 1'b0);
      checks++; if (obs_lat != LAT) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, obs_lat, LAT); end
      checks++; if (resp_a !== exp_resp(16)) begin errors++; $display("FAIL rand%0d_resp_a: got %b expected %b", i, resp_a, exp_resp(16)); end
      checks++; if (resp_b !== exp_resp(4)) begin errors++; $display("FAIL rand%0d_resp_b: got %b expected %b", i, resp_b, exp_resp(4)); end
      do_ack();
    end
  endtask

  task automatic test_ignore();
    logic [7:0]   base;
    logic [R-1:0] held;
    int           bad;
    rand_periods();
    base = 8'($urandom_range(0, 15));
    do_request(base, 1'b1);
    checks++; if (obs_lat != LAT) begin errors++; $display("FAIL ign_latency: got %0d expected %0d", obs_lat, LAT); end
    checks++; if (obs_nchall != R || obs_chall[1] !== base + 8'd1) begin
      errors++; $display("FAIL ign_chall: got n=%0d c1=%h expected n=%0d c1=%h", obs_nchall, obs_chall[1], R, base + 8'd1);
    end
    checks++; if (resp_a !== exp_resp(16)) begin errors++; $display("FAIL ign_resp: got %b expected %b", resp_a, exp_resp(16)); end
    held = resp_a;
    bad  = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid_a !== 1'b1 || resp_a !== held) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ign_hold: got %0d bad cycles expected 0", bad); end
    @(negedge clk);
    ack = 1'b1;
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL ack_same_cycle: valid %b expected 1", valid_a); end
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL ack_drop: valid %b busy %b expected 0 0", valid_a, busy_a);
    end
    checks++; if (resp_a !== held) begin errors++; $display("FAIL ack_resp_kept: got %b expected %b", resp_a, held); end
    repeat (10) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL start_not_queued: busy %b expected 0", busy_a); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < R; k++) begin per0[k] = 4; per1[k] = 8; end
    @(negedge clk);
    challenge = 8'h3C;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    repeat (2 * BIT_CYC + S + 10) @(negedge clk);
    checks++; if (resp_a !== 4'b0011 || ro_en_a !== 1'b1) begin
      errors++; $display("FAIL mid_partial: resp %b ro_en %b expected 0011 1", resp_a, ro_en_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ro_en_a, busy_a, resp_a, valid_a} !== 7'h0) begin
      errors++; $display("FAIL mid_async_reset: got %h expected 0", {ro_en_a, busy_a, resp_a, valid_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_periods();
    do_request(8'($urandom), 1'b0);
    checks++; if (obs_lat != LAT) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", obs_lat, LAT); end
    checks++; if (resp_a !== exp_resp(16)) begin errors++; $display("FAIL post_reset_resp_a: got %b expected %b", resp_a, exp_resp(16)); end
    checks++; if (resp_b !== exp_resp(4)) begin errors++; $display("FAIL post_reset_resp_b: got %b expected %b", resp_b, exp_resp(4)); end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_pattern();
    test_wrap();
    test_saturation();
    test_random();
    test_ignore();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ro_puf_ctrl.md
# ro_puf_ctrl

Sequencer for the dual ring-oscillator PUF array. It steps an 8-bit challenge through the two 256:1 RO multiplexers, enables the oscillators for a settle period and then a measurement window, and counts rising edges on both mux outputs. After each window it compares the two counts to form one response bit, then assembles RESP_BITS bits into a response word. It sits between the user/host logic and the RO array plus mux pair, replacing direct switch/button drive of the challenge and enable lines.

## Interface
- RESP_BITS, 8: response bits per request (1..16).
- SETTLE_CYCLES, 16: cycles the ROs run before counting starts (≥4).
- WIN_CYCLES, 4096: measurement window length in cycles (≥1).
- CNT_W, 16: edge-counter width. Counters saturate.

- CLK100MHZ  in  1  system clock; single clock domain.
- CPU_RESETN  in  1  reset, asynchronous assert, active-low.
- start  in  1  request pulse; accepted only in IDLE.
- challenge  in  8  base challenge, sampled with an accepted start.
- busy  out  1  high in every state except IDLE.
- ro_en  out  1  enable to both RO banks (ROEN0/ROEN1).
- chall  out  8  select to both muxes (chall0/chall1).
- ro_in0  in  1  mux0 output, asynchronous.
- ro_in1  in  1  mux1 output, asynchronous.
- resp  out  RESP_BITS  response word.
- resp_valid  out  1  response available.
- resp_ack  in  1  consumer accepts the response.

## Operation
- States: IDLE, SETTLE, COUNT, COMPARE, DONE. The state enum is registered.
- IDLE → SETTLE on `start`:
  - Latch `challenge` as base, clear bit index k and `resp`.
  - Drive `chall` = base.
- SETTLE:
  - `ro_en`=1.
  - Both edge counters are held cleared.
  - Runs SETTLE_CYCLES cycles, then → COUNT.
- COUNT:
  - `ro_en`=1.
  - Counters increment on each synchronized rising edge. Each input passes through a 2-flop synchronizer and then a rising-edge detector.
  - Runs WIN_CYCLES cycles, then → COMPARE.
- COMPARE (1 cycle):
  - `ro_en`=0.
  - `resp[k]` = (cnt0 > cnt1). A tie gives 0.
  - If k = RESP_BITS−1 → DONE. Otherwise k++, `chall` = base+k (mod 256, wraps 0xFF→0x00), → SETTLE.
- DONE:
  - `resp_valid`=1, `ro_en`=0.
  - On `resp_ack` → IDLE. `resp_valid` drops the following cycle.
  - `resp` holds its value until the next accepted start.
- Input handling:
  - `start` outside IDLE is ignored, and is not queued.
  - `resp_ack` outside DONE is ignored.
- Counters saturate at 2^CNT_W−1. Two saturated counts are a tie and give 0.
- Input rate: the `ro_in*` inputs must toggle at no more than CLK/4. Faster oscillators are prescaled in the RO cell. The controller only counts sampled edges.
- Reset, including mid-operation:
  - Outputs: `ro_en`=0, `chall`=0, `busy`=0, `resp`=0, `resp_valid`=0.
  - Internals: state IDLE, counters 0, synchronizers 0.
  - No partial response survives reset.

## Timing
- All outputs are registered. Both channels have the same sync/detect latency of 3 cycles, so the comparison is unbiased.
- Edges that occur during the last 3 SETTLE cycles are counted in COUNT. This is the same on both channels.
- Start accepted at edge t:
  - `busy`, `ro_en` and `chall` are valid from t+1.
  - Each bit takes SETTLE_CYCLES + WIN_CYCLES + 1 cycles.
  - `resp_valid` rises at t+1+RESP_BITS·(SETTLE_CYCLES+WIN_CYCLES+1).
- `ro_en` is low for exactly 1 cycle (COMPARE) between consecutive bits.
- `chall` changes only on entry to SETTLE, never while `ro_en` is counted.
- `start` and `resp_ack` are both single-cycle level samples; no pulse-width requirement.

## Structure
- Package `puf_pkg`: state enum `puf_state_t`, challenge width constant `CHALL_W`=8, and default parameter constants.
- Sub-module `ro_edge_counter`, instantiated twice:
  - 2-flop synchronizer, rising-edge detector, saturating CNT_W counter.
  - Controls: `clr`, `en`.
  - Same clock and reset as the parent.
- The top-level RO/mux instantiation connects to `ro_en`, `chall` and `ro_in0`/`ro_in1` in place of the button and switch nets.

## Test plan
Parameters for these tests: SETTLE=4, WIN=64, RESP_BITS=4, CNT_W=16.
- ro_in0 period 4 clk, ro_in1 period 8 clk → per bit cnt0=16, cnt1=8; resp=4'b1111; resp_valid exactly at t+1+4·69.
- Swap the periods on odd bits → resp=4'b1010; equal periods on all bits → resp=4'b0000 (tie rule).
- challenge=0xFE, RESP_BITS=4 → `chall` sequence 0xFE, 0xFF, 0x00, 0x01. `ro_en` low for exactly 1 cycle between bits and 0 in DONE.
- CNT_W=4, ro_in0 period 4 (16 edges), ro_in1 period 6 (≥10 edges) → cnt0 saturates at 15, bit=1. Both inputs period 4 → both saturate, bit=0.
- CPU_RESETN low mid-COUNT of bit 2 → `ro_en`/`busy`/`resp`/`resp_valid` go to 0 asynchronously. A new start afterwards produces a full correct response.
- `start` pulsed while busy, and `resp_ack` held low in DONE → both are ignored; `resp_valid` stays high until ack, then drops the next cycle with `resp` unchanged.
